// File: rtl/tile_rom_arbiter_if.sv
// Layer-facing request/response bundle plus the tile ROM port of the arbiter.
interface tile_rom_arbiter_if #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 24
);
  logic [NUM_REQ-1:0]        i_req;
  logic [NUM_REQ*ADDR_W-1:0] i_addr;
  logic                      i_clr_overrun;
  logic [DATA_W-1:0]         i_rom_data;
  logic [ADDR_W-1:0]         o_rom_address;
  logic [DATA_W-1:0]         o_data;
  logic [NUM_REQ-1:0]        o_valid;
  logic [NUM_REQ-1:0]        o_gnt;
  logic                      o_busy;
  logic [NUM_REQ-1:0]        o_overrun;

  modport slave (
    input  i_req, i_addr, i_clr_overrun, i_rom_data,
    output o_rom_address, o_data, o_valid, o_gnt, o_busy, o_overrun
  );

  modport master (
    output i_req, i_addr, i_clr_overrun, i_rom_data,
    input  o_rom_address, o_data, o_valid, o_gnt, o_busy, o_overrun
  );
endinterface

// File: rtl/tile_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous tile ROM among the layer renderers;
// one queued request per layer, texel returned with a one-hot valid strobe.
module tile_rom_arbiter #(
  parameter int unsigned NUM_REQ     = 3,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 24,
  parameter int unsigned ROM_LATENCY = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  tile_rom_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t             r_state;
  logic [NUM_REQ-1:0] r_pending;
  logic [ADDR_W-1:0]  r_addr [NUM_REQ];
  logic [PTR_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]  r_rom_address;
  logic [DATA_W-1:0]  r_data;
  logic [NUM_REQ-1:0] r_valid;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_overrun;

  logic               w_any;
  logic               w_grant_en;
  logic [PTR_W-1:0]   w_idx;
  logic [PTR_W-1:0]   w_win;
  logic [NUM_REQ-1:0] w_win_oh;
  logic [NUM_REQ-1:0] w_ovr_set;

  // Round-robin pick: walk the ring from farthest to nearest so ptr+1 wins last.
  always_comb begin
    w_any = |r_pending;
    w_idx = r_ptr;
    w_win = r_ptr;
    for (int i = int'(NUM_REQ); i >= 1; i--) begin
      w_idx = PTR_W'((int'(r_ptr) + i) % int'(NUM_REQ));
      if (r_pending[w_idx]) begin
        w_win = w_idx;
      end
    end
  end

  assign w_grant_en = (r_state == ST_IDLE) && w_any;
  assign w_win_oh   = w_grant_en ? (NUM_REQ'(1) << w_win) : '0;
  // A re-pulse on the requester's own grant edge re-queues it without an overrun.
  assign w_ovr_set  = bus.i_req & r_pending & ~w_win_oh;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_pending     <= '0;
      for (int k = 0; k < int'(NUM_REQ); k++) begin
        r_addr[k] <= '0;
      end
      r_ptr         <= PTR_W'(NUM_REQ - 1);
      r_cnt         <= '0;
      r_rom_address <= '0;
      r_data        <= '0;
      r_valid       <= '0;
      r_gnt         <= '0;
      r_overrun     <= '0;
    end else begin
      r_valid   <= '0;
      r_overrun <= (bus.i_clr_overrun ? '0 : r_overrun) | w_ovr_set;
      r_pending <= (r_pending & ~w_win_oh) | bus.i_req;
      for (int k = 0; k < int'(NUM_REQ); k++) begin
        if (bus.i_req[k]) begin
          r_addr[k] <= bus.i_addr[k*ADDR_W +: ADDR_W];
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_rom_address <= r_addr[w_win];
            r_gnt         <= w_win_oh;
            r_ptr         <= w_win;
            r_cnt         <= CNT_W'(ROM_LATENCY - 1);
            r_state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_data  <= bus.i_rom_data;
            r_valid <= r_gnt;
            r_gnt   <= '0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_rom_address = r_rom_address;
  assign bus.o_data        = r_data;
  assign bus.o_valid       = r_valid;
  assign bus.o_gnt         = r_gnt;
  assign bus.o_busy        = (r_state != ST_IDLE);
  assign bus.o_overrun     = r_overrun;

endmodule

// File: tb/tb_tile_rom_arbiter.sv
// Self-checking bench for tile_rom_arbiter: scenario tasks plus an
// event-timeline reference model (grant edge, capture edge = grant + latency).
module tb_tile_rom_arbiter;

  localparam int NR = 3;
  localparam int AW = 8;
  localparam int DW = 24;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic [NR-1:0]    tb_req;
  logic [NR*AW-1:0] tb_addr;
  logic             tb_clr;
  logic [DW-1:0]    rom_q;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tile_rom_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) ifc ();

  tile_rom_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .ROM_LATENCY(LAT)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (ifc)
  );

  assign ifc.i_req         = tb_req;
  assign ifc.i_addr        = tb_addr;
  assign ifc.i_clr_overrun = tb_clr;
  assign ifc.i_rom_data    = rom_q;

  logic [NR-1:0] o_gnt, o_valid, o_overrun;
  logic          o_busy;
  logic [AW-1:0] o_rom_address;
  logic [DW-1:0] o_data;
  assign o_gnt         = ifc.o_gnt;
  assign o_valid       = ifc.o_valid;
  assign o_overrun     = ifc.o_overrun;
  assign o_busy        = ifc.o_busy;
  assign o_rom_address = ifc.o_rom_address;
  assign o_data        = ifc.o_data;

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return {a ^ 8'hA5, ~a, a + 8'h3C};
  endfunction

  // ROM with LAT=2: one register stage after the registered address.
  always @(posedge clk) rom_q <= rom_word(o_rom_address);

  // Reference model: pending slots, newest address wins, ring search from last winner.
  bit            m_pend [NR];
  logic [AW-1:0] m_addr [NR];
  int            m_ptr, m_owner, m_cap, m_edge, m_win;
  logic [AW-1:0] m_owner_addr;
  bit            m_other_pend;
  logic [NR-1:0] m_set;
  logic [NR-1:0] exp_gnt, exp_valid, exp_ovr;
  logic          exp_busy;
  logic [AW-1:0] exp_rom_addr;
  logic [DW-1:0] exp_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NR; k++) begin m_pend[k] = 1'b0; m_addr[k] = '0; end
      m_ptr = NR - 1; m_owner = -1; m_cap = 0; m_edge = 0; m_other_pend = 1'b0;
      m_owner_addr = '0;
      exp_gnt = '0; exp_valid = '0; exp_ovr = '0; exp_busy = 1'b0;
      exp_rom_addr = '0; exp_data = '0;
    end else begin
      exp_valid = '0;
      m_win = -1;
      if (m_owner >= 0 && m_edge == m_cap) begin
        exp_valid = NR'(1 << m_owner);
        exp_data  = rom_word(m_owner_addr);
        m_owner   = -1;
      end else if (m_owner < 0) begin
        for (int d = 1; d <= NR; d++)
          if (m_win < 0 && m_pend[(m_ptr + d) % NR]) m_win = (m_ptr + d) % NR;
        if (m_win >= 0) begin
          m_other_pend = 1'b0;
          for (int k = 0; k < NR; k++) if (k != m_win && m_pend[k]) m_other_pend = 1'b1;
          m_owner = m_win; m_owner_addr = m_addr[m_win]; exp_rom_addr = m_addr[m_win];
          m_cap = m_edge + LAT; m_ptr = m_win; m_pend[m_win] = 1'b0;
        end
      end
      m_set = '0;
      for (int k = 0; k < NR; k++) begin
        if (tb_req[k]) begin
          if (m_pend[k]) m_set[k] = 1'b1;
          m_pend[k] = 1'b1;
          m_addr[k] = tb_addr[k*AW +: AW];
        end
      end
      exp_ovr  = (tb_clr ? '0 : exp_ovr) | m_set;
      exp_busy = (m_owner >= 0);
      exp_gnt  = (m_owner >= 0) ? NR'(1 << m_owner) : '0;
      m_edge++;
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({o_gnt, o_valid, o_busy, o_overrun, o_rom_address, o_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_zero: got gnt=%b val=%b busy=%b ovr=%b addr=%h data=%h, want all 0",
               o_gnt, o_valid, o_busy, o_overrun, o_rom_address, o_data);
    end
    n_checks++;
    if ({o_gnt, o_valid, o_busy, o_overrun, o_rom_address, o_data} !==
        {exp_gnt, exp_valid, exp_busy, exp_ovr, exp_rom_addr, exp_data}) begin
      n_fail++;
      $display("FAIL reset_model: got gnt=%b val=%b busy=%b, want gnt=%b val=%b busy=%b",
               o_gnt, o_valid, o_busy, exp_gnt, exp_valid, exp_busy);
    end
  endtask

  task automatic test_single();
    int busy_cycles = 0;
    @(negedge clk);
    tb_req = 3'b001; tb_addr = {16'h0, 8'h2C};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      tb_req = '0;
      n_checks++;
      if ({o_gnt, o_valid, o_busy, o_overrun, o_rom_address, o_data} !==
          {exp_gnt, exp_valid, exp_busy, exp_ovr, exp_rom_addr, exp_data}) begin
        n_fail++;
        $display("FAIL single_model c%0d: got gnt=%b val=%b busy=%b ovr=%b addr=%h data=%h, want gnt=%b val=%b busy=%b ovr=%b addr=%h data=%h",
                 c, o_gnt, o_valid, o_busy, o_overrun, o_rom_address, o_data,
                 exp_gnt, exp_valid, exp_busy, exp_ovr, exp_rom_addr, exp_data);
      end
      busy_cycles += int'(o_busy);
      if (c == 1) begin
        n_checks++;
        if (o_rom_address !== 8'h2C || o_gnt !== 3'b001) begin
          n_fail++;
          $display("FAIL single_grant: got addr=%h gnt=%b, want addr=2c gnt=001", o_rom_address, o_gnt);
        end
      end
      if (c == 3) begin
        n_checks++;
        if (o_valid !== 3'b001 || o_data !== rom_word(8'h2C)) begin
          n_fail++;
          $display("FAIL single_capture: got val=%b data=%h, want val=001 data=%h", o_valid, o_data, rom_word(8'h2C));
        end
      end
      if (c == 4) begin
        n_checks++;
        if (o_valid !== 3'b000) begin
          n_fail++;
          $display("FAIL single_strobe_len: got val=%b, want 000", o_valid);
        end
      end
    end
    n_checks++;
    if (busy_cycles != 2) begin
      n_fail++;
      $display("FAIL single_busy_len: got %0d busy cycles, want 2", busy_cycles);
    end
  endtask

  task automatic test_simultaneous();
    int k;
    apply_reset();
    tb_req = 3'b111; tb_addr = {8'h30, 8'h20, 8'h10};
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      tb_req = '0;
      n_checks++;
      if ({o_gnt, o_valid, o_busy, o_overrun, o_rom_address, o_data} !==
          {exp_gnt, exp_valid, exp_busy, exp_ovr, exp_rom_addr, exp_data}) begin
        n_fail++;
        $display("FAIL simul_model c%0d: got gnt=%b val=%b busy=%b addr=%h data=%h, want gnt=%b val=%b busy=%b addr=%h data=%h",
                 c, o_gnt, o_valid, o_busy, o_rom_address, o_data,
                 exp_gnt, exp_valid, exp_busy, exp_rom_addr, exp_data);
      end
      if (c == 1 || c == 4 || c == 7) begin
        k = (c - 1) / 3;
        n_checks++;
        if (o_gnt !== NR'(1 << k) || o_rom_address !== AW'(8'h10 * (k + 1))) begin
          n_fail++;
          $display("FAIL simul_grant c%0d: got gnt=%b addr=%h, want gnt=%b addr=%h",
                   c, o_gnt, o_rom_address, NR'(1 << k), AW'(8'h10 * (k + 1)));
        end
      end
      if (c == 3 || c == 6 || c == 9) begin
        k = (c - 3) / 3;
        n_checks++;
        if (o_valid !== NR'(1 << k) || o_data !== rom_word(AW'(8'h10 * (k + 1)))) begin
          n_fail++;
          $display("FAIL simul_capture c%0d: got val=%b data=%h, want val=%b data=%h",
                   c, o_valid, o_data, NR'(1 << k), rom_word(AW'(8'h10 * (k + 1))));
        end
      end
    end
  endtask

  task automatic test_fairness();
    int r1_at = 20 + int'($urandom_range(0, 40));
    int r1_arm = -1;
    int grants_since = -1;
    int last_w = -1;
    int w;
    bit r1_done = 1'b0;
    logic [NR-1:0] prev_gnt = '0;
    @(negedge clk);
    tb_req = 3'b101; tb_addr = NR*AW'($urandom);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      tb_req = '0;
      n_checks++;
      if ({o_gnt, o_valid, o_busy, o_overrun, o_rom_address, o_data} !==
          {exp_gnt, exp_valid, exp_busy, exp_ovr, exp_rom_addr, exp_data}) begin
        n_fail++;
        $display("FAIL fair_model c%0d: got gnt=%b val=%b busy=%b addr=%h data=%h, want gnt=%b val=%b busy=%b addr=%h data=%h",
                 c, o_gnt, o_valid, o_busy, o_rom_address, o_data,
                 exp_gnt, exp_valid, exp_busy, exp_rom_addr, exp_data);
      end
      if (o_gnt != '0 && prev_gnt == '0) begin
        w = o_gnt[0] ? 0 : (o_gnt[1] ? 1 : 2);
        n_checks++;
        if (w == last_w && m_other_pend) begin
          n_fail++;
          $display("FAIL fair_repeat c%0d: got requester %0d granted twice, want another pending requester", c, w);
        end
        last_w = w;
        if (grants_since >= 0) begin
          grants_since++;
          if (w == 1) begin
            n_checks++;
            if (grants_since > 2) begin
              n_fail++;
              $display("FAIL fair_r1_latency: got grant at arbitration %0d, want <= 2", grants_since);
            end
            grants_since = -1;
            r1_done = 1'b1;
          end
        end
      end
      prev_gnt = o_gnt;
      if (c == r1_arm) grants_since = 0;
      tb_addr = NR*AW'($urandom);
      if (c < 170) begin
        if (o_valid[0]) tb_req[0] = 1'b1;
        if (o_valid[2]) tb_req[2] = 1'b1;
      end
      if (c == r1_at) begin
        tb_req[1] = 1'b1;
        r1_arm = c + 1;
      end
    end
    n_checks++;
    if (!r1_done) begin
      n_fail++;
      $display("FAIL fair_r1_served: got no grant for requester 1, want one");
    end
  endtask

  task automatic test_overrun();
    apply_reset();
    tb_req = 3'b001; tb_addr = {16'h0, 8'h11};
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      tb_req = '0; tb_clr = 1'b0;
      n_checks++;
      if ({o_gnt, o_valid, o_busy, o_overrun, o_rom_address, o_data} !==
          {exp_gnt, exp_valid, exp_busy, exp_ovr, exp_rom_addr, exp_data}) begin
        n_fail++;
        $display("FAIL ovr_model c%0d: got gnt=%b val=%b busy=%b ovr=%b addr=%h data=%h, want gnt=%b val=%b busy=%b ovr=%b addr=%h data=%h",
                 c, o_gnt, o_valid, o_busy, o_overrun, o_rom_address, o_data,
                 exp_gnt, exp_valid, exp_busy, exp_ovr, exp_rom_addr, exp_data);
      end
      if (c == 1 || c == 2 || c == 10 || c == 11) begin
        n_checks++;
        if (o_overrun !== ((c == 1 || c == 11) ? 3'b000 : 3'b010)) begin
          n_fail++;
          $display("FAIL ovr_flag c%0d: got %b, want %b", c, o_overrun, (c == 1 || c == 11) ? 3'b000 : 3'b010);
        end
      end
      if (c == 6) begin
        n_checks++;
        if (o_valid !== 3'b010 || o_data !== rom_word(8'h06)) begin
          n_fail++;
          $display("FAIL ovr_newest: got val=%b data=%h, want val=010 data=%h", o_valid, o_data, rom_word(8'h06));
        end
      end
      case (c)
        0:  begin tb_req = 3'b010; tb_addr = {8'h0, 8'h05, 8'h0}; end
        1:  begin tb_req = 3'b010; tb_addr = {8'h0, 8'h06, 8'h0}; end
        7:  begin tb_req = 3'b001; tb_addr = {8'h0, 8'h0, 8'h12}; end
        8:  begin tb_req = 3'b010; tb_addr = {8'h0, 8'h07, 8'h0}; end
        9:  begin tb_req = 3'b010; tb_addr = {8'h0, 8'h08, 8'h0}; tb_clr = 1'b1; end
        10: tb_clr = 1'b1;
        default: ;
      endcase
    end
  endtask

  task automatic test_same_edge_regrant();
    @(negedge clk);
    tb_req = 3'b001; tb_addr = {16'h0, 8'h40};
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tb_req = (c == 0) ? 3'b001 : 3'b000;
      n_checks++;
      if ({o_gnt, o_valid, o_busy, o_overrun, o_rom_address, o_data} !==
          {exp_gnt, exp_valid, exp_busy, exp_ovr, exp_rom_addr, exp_data}) begin
        n_fail++;
        $display("FAIL regrant_model c%0d: got gnt=%b val=%b busy=%b ovr=%b addr=%h data=%h, want gnt=%b val=%b busy=%b ovr=%b addr=%h data=%h",
                 c, o_gnt, o_valid, o_busy, o_overrun, o_rom_address, o_data,
                 exp_gnt, exp_valid, exp_busy, exp_ovr, exp_rom_addr, exp_data);
      end
      if (c == 4) begin
        n_checks++;
        if (o_gnt !== 3'b001 || o_rom_address !== 8'h40) begin
          n_fail++;
          $display("FAIL regrant_second: got gnt=%b addr=%h, want gnt=001 addr=40", o_gnt, o_rom_address);
        end
      end
      if (c == 3 || c == 6) begin
        n_checks++;
        if (o_valid !== 3'b001 || o_data !== rom_word(8'h40) || o_overrun !== 3'b000) begin
          n_fail++;
          $display("FAIL regrant_capture c%0d: got val=%b data=%h ovr=%b, want val=001 data=%h ovr=000",
                   c, o_valid, o_data, o_overrun, rom_word(8'h40));
        end
      end
    end
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    tb_req = 3'b010; tb_addr = {8'h0, 8'h55, 8'h0};
    @(negedge clk);
    tb_req = 3'b100; tb_addr = {8'h66, 16'h0};
    @(negedge clk);
    tb_req = '0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_gnt, o_valid, o_busy, o_overrun, o_rom_address, o_data} !== '0) begin
      n_fail++;
      $display("FAIL midreset_zero: got gnt=%b val=%b busy=%b ovr=%b addr=%h data=%h, want all 0",
               o_gnt, o_valid, o_busy, o_overrun, o_rom_address, o_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_checks++;
      if (o_valid !== 3'b000 || o_gnt !== 3'b000 ||
          {o_gnt, o_valid, o_busy, o_overrun, o_rom_address, o_data} !==
          {exp_gnt, exp_valid, exp_busy, exp_ovr, exp_rom_addr, exp_data}) begin
        n_fail++;
        $display("FAIL midreset_quiet c%0d: got val=%b gnt=%b busy=%b, want val=000 gnt=000 busy=0", c, o_valid, o_gnt, o_busy);
      end
    end
    tb_req = 3'b111; tb_addr = {8'h93, 8'h92, 8'h91};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tb_req = '0;
      if (c == 1) begin
        n_checks++;
        if (o_gnt !== 3'b001 || o_rom_address !== 8'h91) begin
          n_fail++;
          $display("FAIL midreset_first_grant: got gnt=%b addr=%h, want gnt=001 addr=91", o_gnt, o_rom_address);
        end
      end
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_random();
    for (int c = 0; c < 310; c++) begin
      @(negedge clk);
      n_checks++;
      if ({o_gnt, o_valid, o_busy, o_overrun, o_rom_address, o_data} !==
          {exp_gnt, exp_valid, exp_busy, exp_ovr, exp_rom_addr, exp_data}) begin
        n_fail++;
        $display("FAIL random_model c%0d: got gnt=%b val=%b busy=%b ovr=%b addr=%h data=%h, want gnt=%b val=%b busy=%b ovr=%b addr=%h data=%h",
                 c, o_gnt, o_valid, o_busy, o_overrun, o_rom_address, o_data,
                 exp_gnt, exp_valid, exp_busy, exp_ovr, exp_rom_addr, exp_data);
      end
      if (c < 300) begin
        tb_req  = NR'($urandom) & NR'($urandom);
        tb_addr = NR*AW'($urandom);
        tb_clr  = ($urandom_range(0, 15) == 0);
      end else begin
        tb_req = '0; tb_clr = 1'b0;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; tb_req = '0; tb_addr = '0; tb_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_overrun();
    test_same_edge_regrant();
    test_reset_mid_access();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tile_rom_arbiter.md
# tile_rom_arbiter

Shares the single synchronous tile ROM among up to four layer renderers (background layer, paddle/ball layer, score/text layer). Each layer posts a one-cycle request carrying an 8-bit ROM address. The arbiter queues one request per layer, grants the ROM round-robin, and returns the 24-bit texel to the requesting layer with a one-hot valid strobe. It sits between the layer blocks and the tile ROM instance and is the only block that drives the ROM address.

## Interface
- NUM_REQ, 3, number of requesters; legal values 2..4
- ADDR_W, 8, ROM address width
- DATA_W, 24, ROM data width (RGB888)
- ROM_LATENCY, 2, cycles from the edge that registers `o_rom_address` to the edge where `i_rom_data` is sampled; legal values 1..4
- i_clk  in  1  system clock; the only clock
- i_rst_n  in  1  asynchronous active-low reset
- i_req  in  NUM_REQ  one-cycle request pulse per requester
- i_addr  in  NUM_REQ*ADDR_W  request addresses; requester k uses bits [k*ADDR_W +: ADDR_W], sampled only with i_req[k]
- o_rom_address  out  ADDR_W  ROM address, registered
- i_rom_data  in  DATA_W  ROM read data
- o_data  out  DATA_W  last captured texel; held until the next capture
- o_valid  out  NUM_REQ  one-hot, one-cycle strobe; o_data belongs to requester k when o_valid[k]=1
- o_gnt  out  NUM_REQ  one-hot owner of the in-flight access; all zero when idle
- o_busy  out  1  access in flight (state ≠ IDLE)
- o_overrun  out  NUM_REQ  sticky; bit k set when requester k pulses i_req while its previous request is still pending
- i_clr_overrun  in  1  clears o_overrun; a set event in the same cycle wins

## Operation
- Per requester: a pending bit and an ADDR_W address register. `i_req[k]=1` sets pending[k] and loads addr[k].
- If pending[k] is already set and not being granted this cycle, addr[k] is overwritten and o_overrun[k] is set. Only the newest address is served.
- FSM states: IDLE, WAIT.
- IDLE: if any pending bit is set, select winner w round-robin, searching ptr+1, ptr+2, … modulo NUM_REQ. On that edge:
  - o_rom_address <= addr[w]
  - o_gnt <= onehot(w)
  - pending[w] cleared
  - ptr <= w
  - cnt <= ROM_LATENCY-1
  - state <= WAIT
- Only pending bits as registered at the start of the cycle are eligible. A request arriving in the same cycle is not granted until the next arbitration.
- Grant plus new pulse from the same requester on the same edge: pending stays set with the new address. No overrun is flagged.
- WAIT: if cnt≠0, decrement. If cnt=0, then o_data <= i_rom_data, o_valid <= o_gnt, o_gnt <= 0, state <= IDLE.
- o_valid is registered and deasserts on the following edge unless another capture occurs. Back-to-back captures are impossible, so o_valid is always a single-cycle pulse.
- o_rom_address holds its last value while idle.
- The round-robin pointer updates only on grant.
- Reset (asynchronous, any state, including mid-access):
  - state=IDLE, pending=0, addr=0
  - ptr=NUM_REQ-1, so requester 0 has first priority
  - cnt=0
  - o_rom_address=0, o_data=0, o_valid=0, o_gnt=0, o_busy=0, o_overrun=0
  - An in-flight access is discarded; no valid strobe is issued for it.

## Timing
- Let edge E be the grant edge (o_rom_address updates). Capture occurs at edge E+ROM_LATENCY; o_valid is high in the cycle after that edge.
- Request-to-valid: a pulse sampled at edge T on an idle arbiter is granted at T+1 and captured at T+1+ROM_LATENCY. With the default ROM_LATENCY=2, o_valid is high during the cycle after edge T+3.
- Throughput: one access per ROM_LATENCY+1 cycles, since the capture edge returns to IDLE and the next grant occurs one edge later. Default: 3 cycles per access, so 3 requesters are served within 9 cycles.
- Worst-case wait for a requester with all others continuously pending: (NUM_REQ-1)·(ROM_LATENCY+1) cycles before its grant.
- o_busy = (state≠IDLE), decoded combinationally from the state register.

## Test plan
- Single request: i_req=3'b001, addr0=8'h2C at edge 0. Required: o_rom_address=8'h2C after edge 1; o_data=ROM[8'h2C] and o_valid=3'b001 for one cycle after edge 3; o_busy high for 2 cycles.
- Simultaneous requests: all three pulse at edge 0 (addresses 10/20/30) after reset. Required: grant order 0,1,2 at edges 1,4,7; o_valid strobes 001, 010, 100 after edges 3, 6, 9, each with the matching ROM word.
- Fairness: requesters 0 and 2 re-pulse on every one of their own valid strobes, and requester 1 pulses once. Required: requester 1 is granted no later than the second arbitration after its pulse; no requester is granted twice in a row while another is pending.
- Overrun: requester 1 pulses addr 8'h05 and then 8'h06 while pending. Required: o_overrun=3'b010; only 8'h06 is read. i_clr_overrun coinciding with a third overrun pulse leaves the bit set; i_clr_overrun alone clears it.
- Same-edge regrant: requester 0 pulses with addr 8'h40 on its own grant edge. Required: no overrun; a second access to 8'h40 follows with no pulse lost.
- Reset mid-access: assert i_rst_n low in WAIT. Required: all outputs 0 immediately; no o_valid after release; the first post-reset grant goes to requester 0.
